spi_master: RTL and testbench

Parametrised SPI master: serialises a DATA_W-bit word onto sdo, drives sclk in any of the four CPOL/CPHA modes at a programmable divided rate, and frames the transfer with an active-low chip select. It optionally captures a full-duplex receive word from miso. It replaces the fixed 8-bit, mode-0, transmit-only SPI block and connects sensor and display peripherals to the monitor's control logic.

---
 rtl/spi_master.sv | 168 ++++++++++++++++
 tb/tb_spi_master.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI master: CPOL/CPHA-configurable, divided sclk, active-low chip select, MSB-first transmit.
// Define SPI_MISO_EN to compile in the full-duplex receive path; otherwise rx_dat_o is tied to 0.
module spi_master #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 4,
  parameter bit          CPOL    = 1'b0,
  parameter bit          CPHA    = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] dat_i,
  input  logic              miso_i,
  output logic              sclk_o,
  output logic              sdo_o,
  output logic              cs_n_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rx_dat_o
);

  localparam int unsigned CNT_W  = $clog2(CLK_DIV + 1);
  localparam int unsigned EDGES  = 2 * DATA_W;
  localparam int unsigned EDGE_W = $clog2(EDGES + 1);
  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE  = EDGE_W'(EDGES);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;
  logic [DATA_W-2:0]   tx_q, tx_d;
  logic                sclk_q, sclk_d;
  logic                sdo_q, sdo_d;
  logic                cs_n_q, cs_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                active_c;
  logic                tick_c;
  logic                accept_c;
  logic                sclk_edge_c;
  logic                shift_tx_c;
  logic                capture_c;
  logic                enter_done_c;
  logic [EDGE_W-1:0]   edge_nxt_c;

  // Half-period tick and the number of the sclk edge it would produce
  assign active_c     = (state_q == S_SETUP) || (state_q == S_SHIFT) || (state_q == S_HOLD);
  assign tick_c       = active_c && (cnt_q == '0);
  assign accept_c     = en_i && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign sclk_edge_c  = tick_c && ((state_q == S_SETUP) || (state_q == S_SHIFT));
  assign edge_nxt_c   = edge_q + EDGE_W'(1);
  assign enter_done_c = (state_q == S_HOLD) && tick_c;

  // Launch on the edge opposite to the sampling edge, never past the last bit
  assign shift_tx_c = sclk_edge_c &&
                      (CPHA ? (edge_nxt_c[0] && (edge_nxt_c >= EDGE_W'(3)))
                            : (!edge_nxt_c[0] && (edge_nxt_c <= EDGE_W'(EDGES - 2))));
  assign capture_c  = sclk_edge_c && (edge_nxt_c[0] != CPHA);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (en_i) state_d = S_SETUP;
      S_SETUP: if (tick_c) state_d = S_SHIFT;
      S_SHIFT: if (tick_c && (edge_nxt_c == LAST_EDGE)) state_d = S_HOLD;
      S_HOLD:  if (tick_c) state_d = S_DONE;
      S_DONE:  state_d = en_i ? S_SETUP : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = (active_c && (cnt_q != '0)) ? cnt_q - CNT_W'(1) : CNT_RELOAD;
    edge_d = edge_q;
    tx_d   = tx_q;
    sclk_d = sclk_q;
    sdo_d  = sdo_q;
    if (accept_c) begin
      edge_d = '0;
      tx_d   = dat_i[DATA_W-2:0];
      sdo_d  = dat_i[DATA_W-1];
    end else begin
      if (sclk_edge_c) begin
        edge_d = edge_nxt_c;
        sclk_d = ~sclk_q;
      end
      if (shift_tx_c) begin
        sdo_d = tx_q[DATA_W-2];
        tx_d  = tx_q << 1;
      end
      if (state_d == S_DONE) sdo_d = 1'b0;
    end
    cs_n_d = !((state_d == S_SETUP) || (state_d == S_SHIFT) || (state_d == S_HOLD));
    busy_d = !cs_n_d;
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= CNT_RELOAD;
      edge_q <= '0;
      tx_q   <= '0;
      sclk_q <= CPOL;
      sdo_q  <= 1'b0;
      cs_n_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      edge_q <= edge_d;
      tx_q   <= tx_d;
      sclk_q <= sclk_d;
      sdo_q  <= sdo_d;
      cs_n_q <= cs_n_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign sclk_o = sclk_q;
  assign sdo_o  = sdo_q;
  assign cs_n_o = cs_n_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

`ifdef SPI_MISO_EN
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rx_dat_q, rx_dat_d;

  // Receive shifter; the word is published only when the frame completes
  always_comb begin
    rx_d     = rx_q;
    rx_dat_d = rx_dat_q;
    if (accept_c)       rx_d = '0;
    else if (capture_c) rx_d = {rx_q[DATA_W-2:0], miso_i};
    if (enter_done_c)   rx_dat_d = rx_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_q     <= '0;
      rx_dat_q <= '0;
    end else begin
      rx_q     <= rx_d;
      rx_dat_q <= rx_dat_d;
    end
  end

  assign rx_dat_o = rx_dat_q;
`else
  logic unused_miso;
  logic unused_enter_done;
  logic unused_capture;
  assign unused_miso       = miso_i;
  assign unused_enter_done = enter_done_c;
  assign unused_capture    = capture_c;
  assign rx_dat_o          = '0;
`endif

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a default-mode instance (8 bit, div 4, mode 0)
// and a 16-bit, div 2, CPOL=1/CPHA=1 instance, checked cycle by cycle against a timing model.
module tb_spi_master;

`ifdef SPI_MISO_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  typedef struct packed {
    logic sclk;
    logic sdo;
    logic cs_n;
    logic busy;
    logic done;
  } obs_t;

  typedef struct {
    int          sel;
    logic [15:0] dat;
    int          mmode;   // 0 loopback, 1 const 0, 2 const 1, 3 toggling
    bit          noise;   // en pulses and dat changes while busy
    logic [15:0] rx_full; // expected rx when receive path present
    string       tag;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        en_a, en_b;
  logic [7:0]  dat_a;
  logic [15:0] dat_b;
  logic        miso_a, miso_b;
  logic        sclk_a, sdo_a, cs_n_a, busy_a, done_a;
  logic        sclk_b, sdo_b, cs_n_b, busy_b, done_b;
  logic [7:0]  rx_a;
  logic [15:0] rx_b;

  int mmode;
  int fcyc;
  int checks;
  int failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (mmode)
      0:       begin miso_a = sdo_a;    miso_b = sdo_b;    end
      1:       begin miso_a = 1'b0;     miso_b = 1'b0;     end
      2:       begin miso_a = 1'b1;     miso_b = 1'b1;     end
      default: begin miso_a = fcyc[3]; miso_b = fcyc[3]; end
    endcase
  end

  spi_master #(.DATA_W(8), .CLK_DIV(4), .CPOL(1'b0), .CPHA(1'b0)) u_a (
    .clk_i(clk), .rst_i(rst), .en_i(en_a), .dat_i(dat_a), .miso_i(miso_a),
    .sclk_o(sclk_a), .sdo_o(sdo_a), .cs_n_o(cs_n_a), .busy_o(busy_a),
    .done_o(done_a), .rx_dat_o(rx_a)
  );

  spi_master #(.DATA_W(16), .CLK_DIV(2), .CPOL(1'b1), .CPHA(1'b1)) u_b (
    .clk_i(clk), .rst_i(rst), .en_i(en_b), .dat_i(dat_b), .miso_i(miso_b),
    .sclk_o(sclk_b), .sdo_o(sdo_b), .cs_n_o(cs_n_b), .busy_o(busy_b),
    .done_o(done_b), .rx_dat_o(rx_b)
  );

  // Closed-form expected outputs at cycle c of a frame (c=0 is the accept cycle)
  function automatic obs_t model(input int w, input int d, input bit cpol, input bit cpha,
                                 input logic [15:0] dat, input int c);
    obs_t o;
    int   last;
    int   e;
    int   sh;
    last   = (2 * w + 1) * d + 1;
    o.sclk = cpol;
    o.sdo  = 1'b0;
    o.cs_n = 1'b1;
    o.busy = 1'b0;
    o.done = 1'b0;
    if (c >= 1 && c < last) begin
      o.cs_n = 1'b0;
      o.busy = 1'b1;
      e = (c - 1) / d;
      if (e > 2 * w) e = 2 * w;
      o.sclk = cpol ^ e[0];
      if (!cpha) sh = e / 2;
      else       sh = (e >= 3) ? (e - 1) / 2 : 0;
      if (sh > w - 1) sh = w - 1;
      o.sdo = dat[w - 1 - sh];
    end else if (c == last) begin
      o.done = 1'b1;
    end
    return o;
  endfunction

  task automatic chk(input string name, input int cyc, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic get_obs(input int sel, output obs_t o, output logic [15:0] rx);
    if (sel == 0) begin
      o  = '{sclk: sclk_a, sdo: sdo_a, cs_n: cs_n_a, busy: busy_a, done: done_a};
      rx = {8'h00, rx_a};
    end else begin
      o  = '{sclk: sclk_b, sdo: sdo_b, cs_n: cs_n_b, busy: busy_b, done: done_b};
      rx = rx_b;
    end
  endtask

  task automatic chk_obs(input string tag, input int c, input obs_t got, input obs_t exp);
    chk({tag, ".sclk"}, c, 16'(got.sclk), 16'(exp.sclk));
    chk({tag, ".sdo"},  c, 16'(got.sdo),  16'(exp.sdo));
    chk({tag, ".cs_n"}, c, 16'(got.cs_n), 16'(exp.cs_n));
    chk({tag, ".busy"}, c, 16'(got.busy), 16'(exp.busy));
    chk({tag, ".done"}, c, 16'(got.done), 16'(exp.done));
  endtask

  task automatic drive(input int sel, input logic en, input logic [15:0] dat);
    if (sel == 0) begin
      en_a  = en;
      dat_a = dat[7:0];
    end else begin
      en_b  = en;
      dat_b = dat;
    end
  endtask

  task automatic run_frame(input int sel, input logic [15:0] dat, input int mm, input bit noise,
                           input logic [15:0] rx_exp, input string tag);
    int          w;
    int          d;
    bit          cpol;
    bit          cpha;
    int          last;
    obs_t        got;
    obs_t        exp;
    logic [15:0] rx;
    if (sel == 0) begin w = 8;  d = 4; cpol = 1'b0; cpha = 1'b0; end
    else          begin w = 16; d = 2; cpol = 1'b1; cpha = 1'b1; end
    last = (2 * w + 1) * d + 1;
    @(negedge clk);
    mmode = mm;
    fcyc  = 0;
    drive(sel, 1'b1, dat);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, dat);
    for (int c = 1; c <= last + 1; c++) begin
      fcyc = c;
      get_obs(sel, got, rx);
      exp = model(w, d, cpol, cpha, dat, c);
      chk_obs(tag, c, got, exp);
      if (c >= last) chk({tag, ".rx"}, c, rx, rx_exp);
      if (noise && c >= 2 && c <= last - 4)
        drive(sel, (c % 3) == 0, 16'($urandom));
      else
        drive(sel, 1'b0, dat);
      @(posedge clk);
      #1;
    end
  endtask

  vec_t vecs[7];

  initial begin
    obs_t        got;
    obs_t        exp;
    logic [15:0] rx;
    checks   = 0;
    failures = 0;
    mmode    = 1;
    fcyc     = 0;
    rst      = 1'b1;
    en_a     = 1'b0;
    en_b     = 1'b0;
    dat_a    = '0;
    dat_b    = '0;

    vecs[0] = '{0, 16'h0039, 0, 1'b0, 16'h0039, "a_loop_39"};
    vecs[1] = '{0, 16'h00A6, 2, 1'b0, 16'h00FF, "a_one_a6"};
    vecs[2] = '{0, 16'h0080, 1, 1'b1, 16'h0000, "a_zero_noise"};
    vecs[3] = '{0, 16'h005C, 3, 1'b0, 16'h0055, "a_toggle"};
    vecs[4] = '{0, 16'h0001, 0, 1'b1, 16'h0001, "a_loop_noise"};
    vecs[5] = '{1, 16'hA5C3, 2, 1'b0, 16'hFFFF, "b_one_a5c3"};
    vecs[6] = '{1, 16'h3C96, 0, 1'b1, 16'h3C96, "b_loop_noise"};

    // Reset values on both instances
    repeat (3) @(posedge clk);
    #1;
    get_obs(0, got, rx);
    chk_obs("rst_a", 0, got, '{sclk: 1'b0, sdo: 1'b0, cs_n: 1'b1, busy: 1'b0, done: 1'b0});
    chk("rst_a.rx", 0, rx, 16'h0000);
    get_obs(1, got, rx);
    chk_obs("rst_b", 0, got, '{sclk: 1'b1, sdo: 1'b0, cs_n: 1'b1, busy: 1'b0, done: 1'b0});
    chk("rst_b.rx", 0, rx, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++)
      run_frame(vecs[i].sel, vecs[i].dat, vecs[i].mmode, vecs[i].noise,
                RX_EN ? vecs[i].rx_full : 16'h0000, vecs[i].tag);

    // Asynchronous reset at cycle 30 of a frame
    run_frame(0, 16'h00C5, 0, 1'b0, RX_EN ? 16'h00C5 : 16'h0000, "a_pre_rst");
    @(negedge clk);
    mmode = 0;
    drive(0, 1'b1, 16'h0039);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 16'h0039);
    repeat (29) @(posedge clk);
    #1;
    get_obs(0, got, rx);
    chk_obs("mid_pre", 30, got, model(8, 4, 1'b0, 1'b0, 16'h0039, 30));
    rst = 1'b1;
    #1;
    get_obs(0, got, rx);
    chk_obs("mid_rst", 30, got, '{sclk: 1'b0, sdo: 1'b0, cs_n: 1'b1, busy: 1'b0, done: 1'b0});
    chk("mid_rst.rx", 30, rx, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      chk("post_rst.done", c, 16'(done_a), 16'h0000);
      chk("post_rst.cs_n", c, 16'(cs_n_a), 16'h0001);
    end
    run_frame(0, 16'h0039, 0, 1'b0, RX_EN ? 16'h0039 : 16'h0000, "a_after_rst");

    // Streaming: en held high, second word loaded after the first start
    @(negedge clk);
    mmode = 0;
    drive(0, 1'b1, 16'h005A);
    @(posedge clk);
    #1;
    drive(0, 1'b1, 16'h00C3);
    for (int c = 1; c <= 139; c++) begin
      get_obs(0, got, rx);
      if (c <= 69) exp = model(8, 4, 1'b0, 1'b0, 16'h005A, c);
      else         exp = model(8, 4, 1'b0, 1'b0, 16'h00C3, c - 69);
      chk_obs("stream", c, got, exp);
      if (c == 69)  chk("stream.rx1", c, rx, RX_EN ? 16'h005A : 16'h0000);
      if (c == 138) chk("stream.rx2", c, rx, RX_EN ? 16'h00C3 : 16'h0000);
      if (c == 100) drive(0, 1'b0, 16'h00C3);
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
